// File: rtl/rotate_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rotate_share_ctrl
//
// Two-requester arbiter and sequencer for a shared multi-cycle right-rotate
// datapath. One job (data + rotate amount) is accepted at a time under
// round-robin priority. The job runs through SHW stages, one per clock, where
// stage k rotates right by 2**k when bit k of the amount is set. The result
// is then held on a valid/ready output port together with the owning
// requester ID.
//
// Ports:
//   clk        rising-edge clock
//   clear      synchronous active-high reset
//   req_valid  per-requester job valid (bit i = requester i)
//   req_data   job data, requester i uses [i*WIDTH +: WIDTH]
//   req_shift  rotate-right amount, requester i uses [i*SHW +: SHW]
//   req_ready  per-requester accept, one-hot or zero, only ever high in IDLE
//   out_valid  result valid (HOLD state)
//   out_data   rotated result, stable while out_valid and not out_ready
//   out_id     requester that owns the result
//   out_ready  downstream accept
//   busy       high whenever a job is in flight or being held
// -----------------------------------------------------------------------------
module rotate_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [1:0]         req_valid,
    input  logic [2*WIDTH-1:0] req_data,
    input  logic [2*SHW-1:0]   req_shift,
    output logic [1:0]         req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_id,
    input  logic               out_ready,
    output logic               busy
);

    // Stage counter only needs to address the SHW amount bits.
    localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STG  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   shamt_q;
    logic [KW-1:0]    k_q;
    logic             id_q;
    logic             last_grant_q;

    logic             accept;
    logic             grant_id;
    logic [WIDTH-1:0] grant_data;
    logic [SHW-1:0]   grant_shift;

    // Fixed rotate amount per stage: stage g rotates right by 2**g, so the
    // LSBs wrap into the MSBs.
    logic [WIDTH-1:0] stage_rot [SHW];

    for (genvar g = 0; g < SHW; g++) begin : g_stage
        localparam int AMT = 2 ** g;
        assign stage_rot[g] = {work_q[AMT-1:0], work_q[WIDTH-1:AMT]};
    end

    assign grant_data  = grant_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    assign grant_shift = grant_id ? req_shift[2*SHW-1:SHW]    : req_shift[SHW-1:0];

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        out_valid = 1'b0;
        accept    = 1'b0;
        grant_id  = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // With both requesting, the one that did not win last time
                // goes first; a lone requester always wins.
                if (req_valid == 2'b11) begin
                    grant_id = ~last_grant_q;
                end else begin
                    grant_id = req_valid[1];
                end
                if (req_valid != 2'b00) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_d   = STG;
                end
            end
            STG: begin
                // Full SHW cycles regardless of the amount, so latency is fixed.
                if (k_q == K_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Job capture and rotate stages
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            work_q       <= '0;
            shamt_q      <= '0;
            k_q          <= '0;
            id_q         <= 1'b0;
            // Pretend requester 1 won last so requester 0 wins the first tie.
            last_grant_q <= 1'b1;
        end else if (accept) begin
            // Requester inputs are only sampled here; later changes are ignored.
            work_q       <= grant_data;
            shamt_q      <= grant_shift;
            k_q          <= '0;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
        end else if (state_q == STG) begin
            if (shamt_q[k_q]) begin
                work_q <= stage_rot[k_q];
            end
            k_q <= k_q + 1'b1;
        end
    end

    // work_q does not change in HOLD, so the result stays stable under
    // backpressure.
    assign out_data = work_q;
    assign out_id   = id_q;

endmodule

// File: tb/tb_rotate_share_ctrl.sv
`timescale 1ns/1ps
module tb_rotate_share_ctrl;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic               clk = 1'b0;
    logic               clear;
    logic [1:0]         req_valid;
    logic [2*WIDTH-1:0] req_data;
    logic [2*SHW-1:0]   req_shift;
    logic [1:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_id;
    logic               out_ready;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    rotate_share_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] exp_rdy;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Rotate right by the whole amount at once: low bits of {d,d} >> s.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} >> s;
        return t[7:0];
    endfunction

    task automatic do_reset();
        clear     = 1'b1;
        req_valid = 2'b00;
        req_data  = '0;
        req_shift = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Starts in IDLE, one time unit after an edge.
    task automatic run_vector(input vec_t v, input int idx);
        req_valid = v.valid;
        req_data  = {v.d1, v.d0};
        req_shift = {v.s1, v.s0};
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_ready", idx), int'(req_ready), int'(v.exp_rdy));
        chk($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
        @(posedge clk); #1;
        // Inputs changed after the handshake must not affect the result.
        req_data  = ~req_data;
        req_shift = ~req_shift;
        for (int c = 1; c <= SHW; c++) begin
            chk($sformatf("v%0d_busy_c%0d", idx, c), int'(busy), 1);
            chk($sformatf("v%0d_noout_c%0d", idx, c), int'(out_valid), 0);
            chk($sformatf("v%0d_noready_c%0d", idx, c), int'(req_ready), 0);
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_out_valid", idx), int'(out_valid), 1);
        chk($sformatf("v%0d_out_data", idx), int'(out_data), int'(v.exp_data));
        chk($sformatf("v%0d_out_id", idx), int'(out_id), int'(v.exp_rdy[1]));
        chk($sformatf("v%0d_hold_busy", idx), int'(busy), 1);
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk($sformatf("v%0d_drop_valid", idx), int'(out_valid), 0);
        chk($sformatf("v%0d_drop_busy", idx), int'(busy), 0);
    endtask

    initial begin
        int         hs_cyc [$];
        int         hs_id  [$];
        int         res_id [$];
        logic [7:0] res_d  [$];
        logic [1:0] rv;
        logic [1:0] exp_rdy;
        logic       gid;
        bit         m_idle;
        bit         m_last;
        int         m_cnt;
        logic [7:0] m_data;
        logic       m_id;

        vecs[0] = '{valid: 2'b01, d0: 8'hB4, d1: 8'h00, s0: 3'd5, s1: 3'd0, exp_rdy: 2'b01, exp_data: 8'hA5};
        vecs[1] = '{valid: 2'b10, d0: 8'h00, d1: 8'h01, s0: 3'd0, s1: 3'd7, exp_rdy: 2'b10, exp_data: 8'h02};
        vecs[2] = '{valid: 2'b10, d0: 8'h00, d1: 8'h3C, s0: 3'd0, s1: 3'd0, exp_rdy: 2'b10, exp_data: 8'h3C};
        vecs[3] = '{valid: 2'b11, d0: 8'h0F, d1: 8'h81, s0: 3'd4, s1: 3'd1, exp_rdy: 2'b01, exp_data: 8'hF0};
        vecs[4] = '{valid: 2'b11, d0: 8'h12, d1: 8'h80, s0: 3'd1, s1: 3'd3, exp_rdy: 2'b10, exp_data: 8'h10};
        vecs[5] = '{valid: 2'b11, d0: 8'hC3, d1: 8'h7E, s0: 3'd2, s1: 3'd5, exp_rdy: 2'b01, exp_data: 8'hF0};

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_id", int'(out_id), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // Table of single jobs, including round-robin ties
        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i], i);
        end

        // Backpressure in HOLD with a competing request pending
        req_valid = 2'b01;
        req_data  = {8'h00, 8'h96};
        req_shift = {3'd0, 3'd3};
        out_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_data  = {8'h5A, 8'h96};
        req_shift = {3'd2, 3'd3};
        repeat (SHW) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
            chk($sformatf("bp_data_c%0d", c), int'(out_data), 8'hD2);
            chk($sformatf("bp_id_c%0d", c), int'(out_id), 0);
            chk($sformatf("bp_ready_c%0d", c), int'(req_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        chk("bp_idle_busy", int'(busy), 0);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        chk("bp_pending_grant", int'(req_ready), 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (SHW) @(posedge clk);
        #1;
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_next_data", int'(out_data), 8'h96);
        chk("bp_next_id", int'(out_id), 1);
        @(posedge clk); #1;

        // Reset mid-job (stage k=1) after requester 0 has just won
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hFF};
        req_shift = {3'd0, 3'd1};
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        chk("clr_busy", int'(busy), 0);
        chk("clr_out_valid", int'(out_valid), 0);
        chk("clr_out_data", int'(out_data), 0);
        chk("clr_tie_to_req0", int'(req_ready), 2'b01);
        req_valid = 2'b00;
        repeat (SHW + 1) @(posedge clk);
        #1;
        chk("clr_no_result", int'(out_valid), 0);

        // Both requesting continuously: alternating grants every SHW+2 cycles
        do_reset();
        req_valid = 2'b11;
        req_data  = {8'h80, 8'h11};
        req_shift = {3'd7, 3'd1};
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                hs_cyc.push_back(c);
                hs_id.push_back(int'(req_ready[1]));
            end
            if (out_valid) begin
                res_id.push_back(int'(out_id));
                res_d.push_back(out_data);
            end
            @(posedge clk); #1;
        end
        chk("alt_hs_count", int'(hs_cyc.size() >= 4), 1);
        chk("alt_res_count", int'(res_id.size() >= 4), 1);
        if (hs_cyc.size() >= 4 && res_id.size() >= 4) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("alt_grant%0d", j), hs_id[j], j % 2);
                chk($sformatf("alt_res_id%0d", j), res_id[j], j % 2);
                chk($sformatf("alt_res_data%0d", j), int'(res_d[j]),
                    int'((j % 2 == 1) ? ref_rot(8'h80, 3'd7) : ref_rot(8'h11, 3'd1)));
                if (j > 0) begin
                    chk($sformatf("alt_interval%0d", j), hs_cyc[j] - hs_cyc[j-1], SHW + 2);
                end
            end
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        m_idle = 1'b1;
        m_last = 1'b1;
        m_cnt  = 0;
        m_data = '0;
        m_id   = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rv        = 2'($urandom_range(0, 3));
            req_valid = rv;
            req_data  = 16'($urandom);
            req_shift = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            #1;
            exp_rdy = 2'b00;
            if (m_idle) begin
                if (rv == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
                else             exp_rdy = rv;
                chk("rnd_ready", int'(req_ready), int'(exp_rdy));
                chk("rnd_busy", int'(busy), 0);
                chk("rnd_out_valid", int'(out_valid), 0);
            end else begin
                chk("rnd_ready", int'(req_ready), 0);
                chk("rnd_busy", int'(busy), 1);
                chk("rnd_out_valid", int'(out_valid), int'(m_cnt == SHW));
                if (m_cnt == SHW) begin
                    chk("rnd_out_data", int'(out_data), int'(m_data));
                    chk("rnd_out_id", int'(out_id), int'(m_id));
                end
            end
            @(posedge clk);
            if (clear) begin
                m_idle = 1'b1;
                m_last = 1'b1;
                m_cnt  = 0;
            end else if (m_idle) begin
                if (exp_rdy != 2'b00) begin
                    gid    = exp_rdy[1];
                    m_last = gid;
                    m_id   = gid;
                    m_data = gid ? ref_rot(req_data[15:8], req_shift[5:3])
                                 : ref_rot(req_data[7:0], req_shift[2:0]);
                    m_cnt  = 0;
                    m_idle = 1'b0;
                end
            end else if (m_cnt < SHW) begin
                m_cnt++;
            end else if (out_ready) begin
                m_idle = 1'b1;
            end
            #1;
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotate_share_ctrl.md
Name: rotate_share_ctrl

Overview:
- Two-requester arbiter and sequencer for a shared multi-cycle right-rotate datapath.
- Accepts one rotate job at a time (data + shift amount) from either requester under round-robin priority.
- Runs the job through log2(WIDTH) stages, one per clock, applying rotate-by-1, then by-2, then by-4.
- Presents the result with the requester ID on a valid/ready output port.

Parameters:
- WIDTH, 8, data width; must be a power of two.
- SHW, 3, shift-control width and stage count; WIDTH = 2**SHW is required.

Ports:
- clk  in  1  clock, rising edge.
- clear  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-requester job valid; bit i is requester i.
- req_data  in  2*WIDTH  job data; requester i uses bits [i*WIDTH +: WIDTH].
- req_shift  in  2*SHW  rotate-right amount; requester i uses bits [i*SHW +: SHW].
- req_ready  out  2  per-requester accept; at most one bit high.
- out_valid  out  1  result valid.
- out_data  out  WIDTH  rotated result.
- out_id  out  1  requester that owns the result.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (clear=1 at a rising edge):
  - state <= IDLE; work, out_data <= 0; out_id <= 0; last_grant <= 1, so requester 0 wins first.
  - Outputs after reset: out_valid=0, busy=0, req_ready=0 until the next IDLE evaluation.
  - Reset mid-job discards the job; no result is produced.
- States: IDLE, STG (stage counter k = 0..SHW-1), HOLD.
- IDLE:
  - req_ready is combinational from req_valid and last_grant.
  - One valid requester: it is granted.
  - Both valid: the requester != last_grant is granted.
  - None valid: req_ready = 0.
  - Handshake (req_valid[i] & req_ready[i]): capture work <= data_i, shamt <= shift_i, id <= i; last_grant <= i; k <= 0; go to STG.
- STG:
  - Each cycle: work <= shamt[k] ? rotr(work, 2**k) : work.
  - rotr(x, n) = {x[n-1:0], x[WIDTH-1:n]}; LSBs wrap into MSBs.
  - k increments; after k = SHW-1, go to HOLD.
  - Exactly SHW cycles regardless of shamt; shamt = 0 still takes full latency.
- HOLD:
  - out_valid = 1; out_data = work; out_id = id.
  - out_data and out_id are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: handshake at edge N gives out_valid high in cycle N+SHW+1 (N+4 at defaults).
  - Minimum initiation interval is SHW+2 cycles (5 at defaults).
  - No job is accepted while busy.
- req_ready is 0 in STG and HOLD. Requester inputs are ignored outside IDLE, and changes to req_data or req_shift after the handshake have no effect.
- A requester that deasserts valid before being granted loses nothing; last_grant is updated only on a handshake.
- Backpressure has no timeout; HOLD persists indefinitely while out_ready = 0.
- out_ready while out_valid = 0 is ignored.

Test Plan:
1. Reset, then req0 data=8'hB4 shift=5, accepted at edge N -> out_valid in cycle N+4 with out_data=8'hA5, out_id=0; busy high cycles N+1..N+4.
2. req1 data=8'h01 shift=7 -> out_data=8'h02, out_id=1. Then data=8'h3C shift=0 -> out_data=8'h3C after the same 4-cycle latency.
3. Both req_valid held high from reset with distinct jobs, out_ready=1 -> grants alternate 0,1,0,1. Results show out_id 0,1,0,1, and a new handshake occurs every 5 cycles.
4. Job in HOLD with out_ready=0 for 3 cycles -> out_valid stays 1, out_data and out_id are constant, req_ready=2'b00 despite pending requests. out_ready=1 -> next cycle IDLE and the pending request is granted.
5. clear=1 during STG (k=1) -> next cycle busy=0, out_valid=0, out_data=0. The following grant goes to requester 0 when both request.
6. Change req_data and req_shift of the granted requester the cycle after the handshake -> the result matches the captured values only.
